operand_issue: RTL

- Upstream neighbour of the ALU stage.
- Holds the 32-entry architectural register file and accepts one instruction word per cycle.
- Decodes the opcode, reads both source operands and registers Value1/Value2/OP for the ALU with a valid strobe.
- Accepts ALU results back as writebacks and stalls issue on register hazards via a per-register busy scoreboard.

---
 rtl/operand_issue.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/operand_issue.sv
// Operand issue stage: architectural register file, busy scoreboard and
// registered operand delivery to the ALU, with writeback bypass into the read.
module operand_issue #(
  parameter int WIDTH = 32,
  parameter int NREGS = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             InstrValid,
  input  logic [31:0]      Instr,
  output logic             InstrReady,
  input  logic             WbValid,
  input  logic [4:0]       WbAddr,
  input  logic [WIDTH-1:0] WbData,
  output logic [WIDTH-1:0] Value1,
  output logic [WIDTH-1:0] Value2,
  output logic [5:0]       OP,
  output logic [4:0]       IssueRd,
  output logic             IssueValid,
  output logic             IllegalOp
);

  // Handshake: an instruction transfers on the rising edge where InstrValid
  // and InstrReady are both 1; InstrReady is combinational and may drop while
  // Instr is offered, in which case upstream holds Instr stable until accepted.

  localparam logic [5:0] OP_ADD = 6'b010000;
  localparam logic [5:0] OP_SHR = 6'b000100;
  localparam logic [5:0] OP_SHL = 6'b000101;
  localparam logic [5:0] OP_AND = 6'b001000;
  localparam logic [5:0] OP_OR  = 6'b001001;
  localparam logic [5:0] OP_NOR = 6'b001010;
  localparam logic [5:0] OP_XOR = 6'b001011;

  logic [5:0] opcode;
  logic [4:0] rd;
  logic [4:0] rs;
  logic [4:0] rt;

  assign opcode = Instr[31:26];
  assign rd     = Instr[25:21];
  assign rs     = Instr[20:16];
  assign rt     = Instr[15:11];

  logic [NREGS-1:0][WIDTH-1:0] regs_q, regs_d;
  logic [NREGS-1:0]            busy_q, busy_d;
  logic [WIDTH-1:0]            value1_q, value1_d;
  logic [WIDTH-1:0]            value2_q, value2_d;
  logic [5:0]                  op_q, op_d;
  logic [4:0]                  issue_rd_q, issue_rd_d;
  logic                        issue_valid_q, issue_valid_d;
  logic                        illegal_q, illegal_d;

  logic             legal;
  logic             wb_en;
  logic             rs_hazard;
  logic             rt_hazard;
  logic             rd_hazard;
  logic             hazard;
  logic             accept;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_ADD, OP_SHR, OP_SHL, OP_AND, OP_OR, OP_NOR, OP_XOR: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  // Writebacks to r0 are dropped entirely, so they never bypass or clear.
  assign wb_en = WbValid && (WbAddr != 5'd0);

  // A busy source is not a hazard when its producer writes back this cycle.
  assign rs_hazard = busy_q[rs] && !(wb_en && (WbAddr == rs));
  assign rt_hazard = busy_q[rt] && !(wb_en && (WbAddr == rt));
  assign rd_hazard = (rd != 5'd0) && busy_q[rd] && !(wb_en && (WbAddr == rd));
  assign hazard    = legal && (rs_hazard || rt_hazard || rd_hazard);

  assign InstrReady = !Reset && !hazard;
  assign accept     = InstrValid && InstrReady;

  always_comb begin
    rs_val = regs_q[rs];
    if (rs == 5'd0) begin
      rs_val = '0;
    end else if (wb_en && (WbAddr == rs)) begin
      rs_val = WbData;
    end
  end

  always_comb begin
    rt_val = regs_q[rt];
    if (rt == 5'd0) begin
      rt_val = '0;
    end else if (wb_en && (WbAddr == rt)) begin
      rt_val = WbData;
    end
  end

  always_comb begin
    regs_d = regs_q;
    if (wb_en) begin
      regs_d[WbAddr] = WbData;
    end
    regs_d[0] = '0;
  end

  // Clear on writeback first so a same-cycle set on the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (wb_en) begin
      busy_d[WbAddr] = 1'b0;
    end
    if (accept && legal && (rd != 5'd0)) begin
      busy_d[rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_comb begin
    value1_d      = value1_q;
    value2_d      = value2_q;
    op_d          = op_q;
    issue_rd_d    = issue_rd_q;
    issue_valid_d = 1'b0;
    illegal_d     = 1'b0;
    if (accept) begin
      if (legal) begin
        value1_d      = rs_val;
        value2_d      = rt_val;
        op_d          = opcode;
        issue_rd_d    = rd;
        issue_valid_d = 1'b1;
      end else begin
        illegal_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      regs_q        <= '0;
      busy_q        <= '0;
      value1_q      <= '0;
      value2_q      <= '0;
      op_q          <= '0;
      issue_rd_q    <= '0;
      issue_valid_q <= 1'b0;
      illegal_q     <= 1'b0;
    end else begin
      regs_q        <= regs_d;
      busy_q        <= busy_d;
      value1_q      <= value1_d;
      value2_q      <= value2_d;
      op_q          <= op_d;
      issue_rd_q    <= issue_rd_d;
      issue_valid_q <= issue_valid_d;
      illegal_q     <= illegal_d;
    end
  end

  assign Value1     = value1_q;
  assign Value2     = value2_q;
  assign OP         = op_q;
  assign IssueRd    = issue_rd_q;
  assign IssueValid = issue_valid_q;
  assign IllegalOp  = illegal_q;

endmodule
